// File: rtl/weld_seq_ctrl.sv
// Arc-welding sequence controller: gas pre-purge, arc strike with retries, timed weld,
// gas post-purge, with alarm/abort handling, a latched fault code and a completed-weld counter.
module weld_seq_ctrl #(
    parameter logic [15:0] STRIKE_TIMEOUT = 16'd100,
    parameter logic [1:0]  RETRY_MAX      = 2'd3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        clear,
    input  logic        alarm,
    input  logic        arc_ok,
    input  logic [15:0] pre_cycles,
    input  logic [15:0] weld_cycles,
    input  logic [15:0] post_cycles,
    output logic        gas_en,
    output logic        arc_en,
    output logic        mon_start,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [2:0]  state,
    output logic [15:0] weld_count
);
    localparam logic [2:0] S_IDLE      = 3'b000;
    localparam logic [2:0] S_PREPURGE  = 3'b001;
    localparam logic [2:0] S_STRIKE    = 3'b010;
    localparam logic [2:0] S_WELD      = 3'b011;
    localparam logic [2:0] S_POSTPURGE = 3'b100;
    localparam logic [2:0] S_FAULT     = 3'b101;

    logic [2:0]  state_r, next_s;
    logic [15:0] timer_r, timer_nx_s;
    logic [1:0]  retry_r, retry_nx_s;
    logic        aborted_r, aborted_nx_s;
    logic [15:0] weld_len_r, post_len_r;
    logic        latch_s;
    logic [15:0] weld_count_r, weld_count_nx_s;
    logic [1:0]  fault_code_r, code_nx_s;
    logic        count_end_s;
    logic        gas_nx_s, arc_nx_s, busy_nx_s, fault_nx_s, mon_nx_s, done_nx_s;

    function automatic logic [15:0] min_one(input logic [15:0] n);
        return (n == 16'd0) ? 16'd1 : n;
    endfunction

    // The timer holds the remaining cycles of the current timed state, so 1 marks its last cycle
    assign count_end_s = (timer_r <= 16'd1);

    // State register with timer, retry count, abort flag, latched lengths and weld counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            timer_r      <= 16'd0;
            retry_r      <= 2'd0;
            aborted_r    <= 1'b0;
            weld_len_r   <= 16'd0;
            post_len_r   <= 16'd0;
            weld_count_r <= 16'd0;
            fault_code_r <= 2'b00;
        end else begin
            state_r      <= next_s;
            timer_r      <= timer_nx_s;
            retry_r      <= retry_nx_s;
            aborted_r    <= aborted_nx_s;
            weld_count_r <= weld_count_nx_s;
            fault_code_r <= code_nx_s;
            if (latch_s) begin
                weld_len_r <= weld_cycles;
                post_len_r <= post_cycles;
            end
        end
    end

    // Next-state logic; branch order encodes alarm > abort > arc loss/timeout > count end
    always_comb begin
        next_s          = state_r;
        timer_nx_s      = timer_r - 16'd1;
        retry_nx_s      = retry_r;
        aborted_nx_s    = aborted_r;
        weld_count_nx_s = weld_count_r;
        code_nx_s       = fault_code_r;
        latch_s         = 1'b0;
        case (state_r)
            S_IDLE: begin
                code_nx_s = 2'b00;
                if (start && !alarm) begin
                    next_s       = S_PREPURGE;
                    latch_s      = 1'b1;
                    timer_nx_s   = min_one(pre_cycles);
                    aborted_nx_s = 1'b0;
                end else begin
                    timer_nx_s = 16'd0;
                end
            end
            S_PREPURGE, S_STRIKE, S_WELD: begin
                if (alarm) begin
                    next_s     = S_FAULT;
                    code_nx_s  = 2'b10;
                    timer_nx_s = 16'd0;
                end else if (abort) begin
                    next_s       = S_POSTPURGE;
                    aborted_nx_s = 1'b1;
                    timer_nx_s   = min_one(post_len_r);
                end else if (state_r == S_PREPURGE) begin
                    if (count_end_s) begin
                        next_s     = S_STRIKE;
                        timer_nx_s = min_one(STRIKE_TIMEOUT);
                        retry_nx_s = 2'd0;
                    end else begin
                        next_s = S_PREPURGE;
                    end
                end else if (state_r == S_STRIKE) begin
                    if (arc_ok) begin
                        next_s     = S_WELD;
                        timer_nx_s = min_one(weld_len_r);
                    end else if (count_end_s) begin
                        if (retry_r + 2'd1 == RETRY_MAX) begin
                            next_s     = S_FAULT;
                            code_nx_s  = 2'b01;
                            timer_nx_s = 16'd0;
                        end else begin
                            retry_nx_s = retry_r + 2'd1;
                            timer_nx_s = min_one(STRIKE_TIMEOUT);
                        end
                    end else begin
                        next_s = S_STRIKE;
                    end
                end else begin
                    if (!arc_ok) begin
                        next_s     = S_FAULT;
                        code_nx_s  = 2'b11;
                        timer_nx_s = 16'd0;
                    end else if (count_end_s) begin
                        next_s          = S_POSTPURGE;
                        timer_nx_s      = min_one(post_len_r);
                        weld_count_nx_s = (weld_count_r == 16'hFFFF) ? weld_count_r
                                                                     : weld_count_r + 16'd1;
                    end else begin
                        next_s = S_WELD;
                    end
                end
            end
            S_POSTPURGE: begin
                if (alarm) begin
                    next_s     = S_FAULT;
                    code_nx_s  = 2'b10;
                    timer_nx_s = 16'd0;
                end else if (count_end_s) begin
                    next_s     = S_IDLE;
                    timer_nx_s = 16'd0;
                end else begin
                    next_s = S_POSTPURGE;
                end
            end
            S_FAULT: begin
                timer_nx_s = 16'd0;
                if (clear) begin
                    next_s    = S_IDLE;
                    code_nx_s = 2'b00;
                end else begin
                    next_s = S_FAULT;
                end
            end
            default: begin
                next_s     = S_IDLE;
                timer_nx_s = 16'd0;
                code_nx_s  = 2'b00;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with state
    always_comb begin
        gas_nx_s   = 1'b0;
        arc_nx_s   = 1'b0;
        busy_nx_s  = 1'b0;
        fault_nx_s = 1'b0;
        case (next_s)
            S_PREPURGE, S_POSTPURGE: begin
                gas_nx_s  = 1'b1;
                busy_nx_s = 1'b1;
            end
            S_STRIKE, S_WELD: begin
                gas_nx_s  = 1'b1;
                arc_nx_s  = 1'b1;
                busy_nx_s = 1'b1;
            end
            S_FAULT: begin
                fault_nx_s = 1'b1;
            end
            default: begin
                gas_nx_s = 1'b0;
            end
        endcase
        mon_nx_s  = (state_r == S_STRIKE) && (next_s == S_WELD);
        done_nx_s = (state_r == S_POSTPURGE) && (next_s == S_IDLE) && !aborted_r;
    end

    // Output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gas_en    <= 1'b0;
            arc_en    <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            mon_start <= 1'b0;
            done      <= 1'b0;
        end else begin
            gas_en    <= gas_nx_s;
            arc_en    <= arc_nx_s;
            busy      <= busy_nx_s;
            fault     <= fault_nx_s;
            mon_start <= mon_nx_s;
            done      <= done_nx_s;
        end
    end

    assign state      = state_r;
    assign fault_code = fault_code_r;
    assign weld_count = weld_count_r;

endmodule

// File: tb/tb_weld_seq_ctrl.sv
// Self-checking bench for weld_seq_ctrl: directed scenarios plus randomized stimulus,
// compared every cycle against a phase/elapsed-time reference model.
module tb_weld_seq_ctrl;
    localparam logic [15:0] TO_P   = 16'd4;
    localparam logic [1:0]  RMAX_P = 2'd3;
    localparam int TO = 4, RMAX = 3;
    localparam int IDLE = 0, PRE = 1, STR = 2, WLD = 3, PST = 4, FLT = 5;

    logic clk = 1'b0;
    logic reset_n, start, abort, clear, alarm, arc_ok;
    logic [15:0] pre_cycles, weld_cycles, post_cycles;
    logic gas_en, arc_en, mon_start, busy, done, fault;
    logic [1:0] fault_code;
    logic [2:0] state;
    logic [15:0] weld_count;

    int n_vec = 0, n_err = 0;
    int ph, el, tries, code, cnt, lpre, lweld, lpost;
    bit ab, e_mon, e_done;
    int gas_n, arc_n, mon_n, done_n, strike_n;

    weld_seq_ctrl #(.STRIKE_TIMEOUT(TO_P), .RETRY_MAX(RMAX_P)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .clear(clear),
        .alarm(alarm), .arc_ok(arc_ok), .pre_cycles(pre_cycles), .weld_cycles(weld_cycles),
        .post_cycles(post_cycles), .gas_en(gas_en), .arc_en(arc_en), .mon_start(mon_start),
        .busy(busy), .done(done), .fault(fault), .fault_code(fault_code), .state(state),
        .weld_count(weld_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int len1(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    task automatic model_reset();
        ph = IDLE; el = 0; tries = 0; code = 0; cnt = 0; ab = 0; e_mon = 0; e_done = 0;
    endtask

    // One clock of the reference sequence, using the inputs currently applied
    task automatic model_step();
        int nph;
        nph = ph; e_mon = 0; e_done = 0;
        case (ph)
            IDLE: if (start && !alarm) begin
                nph = PRE; lpre = pre_cycles; lweld = weld_cycles; lpost = post_cycles; ab = 0;
            end
            FLT: if (clear) begin nph = IDLE; code = 0; end
            PRE, STR, WLD, PST: begin
                if (alarm) begin nph = FLT; code = 2; end
                else if (abort && ph != PST) begin nph = PST; ab = 1; end
                else if (ph == PRE) begin
                    if (el + 1 >= len1(lpre)) begin nph = STR; tries = 0; end
                end else if (ph == STR) begin
                    if (arc_ok) begin nph = WLD; e_mon = 1; end
                    else if (el + 1 >= TO) begin
                        tries++;
                        if (tries == RMAX) begin nph = FLT; code = 1; end
                        else el = -1;
                    end
                end else if (ph == WLD) begin
                    if (!arc_ok) begin nph = FLT; code = 3; end
                    else if (el + 1 >= len1(lweld)) begin
                        nph = PST;
                        if (cnt < 65535) cnt++;
                    end
                end else begin
                    if (el + 1 >= len1(lpost)) begin nph = IDLE; e_done = !ab; end
                end
            end
            default: nph = IDLE;
        endcase
        el = (nph != ph) ? 0 : el + 1;
        ph = nph;
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(ph));
        check("gas_en", 32'(gas_en), 32'(ph >= PRE && ph <= PST));
        check("arc_en", 32'(arc_en), 32'(ph == STR || ph == WLD));
        check("busy", 32'(busy), 32'(ph >= PRE && ph <= PST));
        check("fault", 32'(fault), 32'(ph == FLT));
        check("fault_code", 32'(fault_code), 32'(code));
        check("weld_count", 32'(weld_count), 32'(cnt));
        check("mon_start", 32'(mon_start), 32'(e_mon));
        check("done", 32'(done), 32'(e_done));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        gas_n += int'(gas_en); arc_n += int'(arc_en); mon_n += int'(mon_start);
        done_n += int'(done); strike_n += int'(state == 3'b010);
    endtask

    task automatic clear_tallies();
        gas_n = 0; arc_n = 0; mon_n = 0; done_n = 0; strike_n = 0;
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; clear = 1'b0; alarm = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; idle_inputs(); arc_ok = 1'b0;
        pre_cycles = 16'd0; weld_cycles = 16'd0; post_cycles = 16'd0;
        model_reset(); clear_tallies();
        #2;
        compare_all();
        #6 reset_n = 1'b1;
        tick();

        // Normal cycle with lengths changed after acceptance
        clear_tallies();
        pre_cycles = 16'd3; weld_cycles = 16'd5; post_cycles = 16'd2; start = 1'b1;
        tick();
        start = 1'b0; pre_cycles = 16'd9; weld_cycles = 16'd9; post_cycles = 16'd9;
        for (int i = 0; i < 4; i++) tick();
        arc_ok = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("n041_gas", 32'(gas_n), 32'd12);
        check("n041_arc", 32'(arc_n), 32'd7);
        check("n041_mon", 32'(mon_n), 32'd1);
        check("n041_done", 32'(done_n), 32'd1);
        check("n041_count", 32'(weld_count), 32'd1);

        // Strike never succeeds: three attempts of four cycles, then no-strike fault
        clear_tallies();
        arc_ok = 1'b0; pre_cycles = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("n042_strikes", 32'(strike_n), 32'd12);
        check("n042_code", 32'(fault_code), 32'd1);
        check("n042_outs", {30'd0, gas_en, arc_en}, 32'd0);
        clear = 1'b1; tick(); clear = 1'b0;
        check("n042_cleared", {27'd0, state, fault_code}, 32'd0);

        // Alarm during the third weld cycle
        arc_ok = 1'b1; weld_cycles = 16'd8; post_cycles = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        alarm = 1'b1; tick(); alarm = 1'b0;
        check("n043_state", 32'(state), 32'd5);
        check("n043_code", 32'(fault_code), 32'd2);
        check("n043_count", 32'(weld_count), 32'd1);
        clear = 1'b1; tick(); clear = 1'b0;

        // Abort together with arc loss in weld: abort wins
        clear_tallies();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        abort = 1'b1; arc_ok = 1'b0; tick(); abort = 1'b0; arc_ok = 1'b1;
        check("n044_state", 32'(state), 32'd4);
        check("n044_arc", 32'(arc_en), 32'd0);
        clear_tallies();
        for (int i = 0; i < 5; i++) tick();
        check("n044_gas", 32'(gas_n), 32'd2);
        check("n044_done", 32'(done_n), 32'd0);
        check("n044_count", 32'(weld_count), 32'd1);

        // Asynchronous reset mid-weld
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #3 reset_n = 1'b0;
        #1 model_reset();
        compare_all();
        check("n045_outs", {23'd0, gas_en, arc_en, busy, fault, done, mon_start, fault_code, 1'b0},
              32'd0);
        #2 reset_n = 1'b1;
        tick();

        // Zero lengths with a saturated weld counter
        force dut.weld_count_r = 16'hFFFF;
        cnt = 65535;
        tick();
        release dut.weld_count_r;
        clear_tallies();
        pre_cycles = 16'd0; weld_cycles = 16'd0; post_cycles = 16'd0; arc_ok = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("n046_done", 32'(done_n), 32'd1);
        check("n046_gas", 32'(gas_n), 32'd4);
        check("n046_count", 32'(weld_count), 32'hFFFF);

        // Randomized operation, with periodic asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 40) == 0);
            alarm = ($urandom_range(0, 60) == 0);
            clear = ($urandom_range(0, 4) == 0);
            arc_ok = ((i / 300) % 2 == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 7) == 0);
            pre_cycles = 16'($urandom_range(0, 4));
            weld_cycles = 16'($urandom_range(0, 6));
            post_cycles = 16'($urandom_range(0, 4));
            tick();
            if (i % 1000 == 999) begin
                #2 reset_n = 1'b0;
                #1 model_reset();
                compare_all();
                #2 reset_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/weld_seq_ctrl.md
WELD_SEQ_CTRL -- requirements
Module: weld_seq_ctrl

Interface
REQ-001 SHALL have parameter STRIKE_TIMEOUT, default 16'd100: max cycles in STRIKE per attempt.
REQ-002 SHALL have parameter RETRY_MAX, default 2'd3: strike attempts before fault.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  request a weld cycle; sampled only in IDLE.
REQ-006 SHALL have port abort  in  1  operator stop; arc off, gas post-purge.
REQ-007 SHALL have port clear  in  1  leave FAULT; sampled only in FAULT.
REQ-008 SHALL have port alarm  in  1  process-monitor limit violation (temp/pressure/voltage).
REQ-009 SHALL have port arc_ok  in  1  arc established feedback.
REQ-010 SHALL have port pre_cycles  in  16  pre-purge length.
REQ-011 SHALL have port weld_cycles  in  16  weld length.
REQ-012 SHALL have port post_cycles  in  16  post-purge length.
REQ-013 SHALL have port gas_en  out  1  shielding gas valve.
REQ-014 SHALL have port arc_en  out  1  power source enable.
REQ-015 SHALL have port mon_start  out  1  one-cycle pulse starting the process monitor.
REQ-016 SHALL have port busy  out  1  state not IDLE and not FAULT.
REQ-017 SHALL have port done  out  1  one-cycle pulse on normal completion.
REQ-018 SHALL have port fault  out  1  high while in FAULT.
REQ-019 SHALL have port fault_code  out  2  00 none, 01 no-strike, 10 alarm, 11 arc-loss.
REQ-020 SHALL have port state  out  3  current state encoding.
REQ-021 SHALL have port weld_count  out  16  completed welds, saturating.

Function
REQ-022 SHALL implement states IDLE=000, PREPURGE=001, STRIKE=010, WELD=011, POSTPURGE=100, FAULT=101; codes 110/111 SHALL go to IDLE next cycle.
REQ-023 SHALL register all outputs; gas_en=1 in PREPURGE/STRIKE/WELD/POSTPURGE; arc_en=1 in STRIKE/WELD only; FAULT drives both 0.
REQ-024 SHALL latch pre/weld/post_cycles on the start-accept edge; later input changes SHALL NOT affect the running cycle.
REQ-025 SHALL give each timed state a duration of max(N,1) cycles, where N is the latched length (0 treated as 1).
REQ-026 SHALL, in IDLE with start=1 and alarm=0, go to PREPURGE; start with alarm=1 SHALL be ignored.
REQ-027 SHALL go from PREPURGE to STRIKE at count end, loading the timer with STRIKE_TIMEOUT and clearing the retry count.
REQ-028 SHALL go from STRIKE to WELD on arc_ok=1 and pulse mon_start for exactly the first WELD cycle.
REQ-029 SHALL, on a STRIKE timeout, increment the retry count; at retry count==RETRY_MAX go to FAULT with code 01, else reload the timer and stay in STRIKE.
REQ-030 SHALL go from WELD to POSTPURGE at count end, incrementing weld_count by one with saturation at 16'hFFFF.
REQ-031 SHALL, in WELD, go to FAULT with code 11 when arc_ok=0.
REQ-032 SHALL go from POSTPURGE to IDLE at count end, pulsing done unless the cycle was aborted.
REQ-033 SHALL, on alarm=1 in PREPURGE, STRIKE, WELD or POSTPURGE, go to FAULT with code 10.
REQ-034 SHALL, on abort=1 in PREPURGE, STRIKE or WELD, go to POSTPURGE with an aborted flag set, suppressing done and the weld_count increment.
REQ-035 SHALL ignore abort in POSTPURGE.
REQ-036 SHALL apply same-cycle priority: alarm > abort > arc loss/strike timeout > count end.
REQ-037 SHALL hold FAULT until clear=1, then go to IDLE with fault_code=00; fault_code SHALL persist while in FAULT.
REQ-038 SHALL ignore start while busy.

Reset
REQ-039 SHALL, while reset_n=0, force state=IDLE, all outputs 0, weld_count=0, and clear timer, retry count and aborted flag immediately, regardless of clk.
REQ-040 SHALL apply reset mid-operation with the same result; the first edge after release SHALL evaluate IDLE.

Verification
REQ-041 SHALL pass: pre=3, weld=5, post=2, arc_ok 2 cycles into STRIKE -> gas_en on 10+ cycles, arc_en on during STRIKE+WELD, one mon_start, one done, weld_count 0->1.
REQ-042 SHALL pass: arc_ok held 0 with STRIKE_TIMEOUT=4 -> FAULT after 12 STRIKE cycles, fault_code=01, gas_en=arc_en=0; clear -> IDLE, code 00.
REQ-043 SHALL pass: alarm=1 on the 3rd WELD cycle -> next state FAULT, code 10, weld_count unchanged.
REQ-044 SHALL pass: abort together with arc_ok drop in WELD -> POSTPURGE (abort wins), arc_en=0, gas_en=1 for post cycles, no done pulse, weld_count unchanged.
REQ-045 SHALL pass: reset_n low mid-WELD between clock edges -> all outputs 0 immediately, weld_count=0.
REQ-046 SHALL pass: all lengths 0 with arc_ok=1 -> PREPURGE, WELD, POSTPURGE each 1 cycle, done asserted; weld_count preloaded 16'hFFFF stays 16'hFFFF.
